sa_cache_mem_ctrl: RTL and testbench



---
 rtl/sa_cache_mem_ctrl_if.sv | 37 +++
 rtl/sa_cache_mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sa_cache_mem_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_cache_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// sa_cache_mem_ctrl_if
// Single req/ack memory port used by sa_cache_mem_ctrl.
//   mem_req   : request valid, held until mem_ack
//   mem_we    : 1 = write (writeback), 0 = read (fill)
//   mem_addr  : line address, offset bits [5:0] always zero
//   mem_wdata : writeback data
//   mem_ack   : memory accepts/completes the current request
//   mem_rdata : fill data, valid with mem_ack on a read
// Modports: master (controller side), slave (memory side).
// ----------------------------------------------------------------------------
interface sa_cache_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/sa_cache_mem_ctrl.sv
// ----------------------------------------------------------------------------
// sa_cache_mem_ctrl
// Miss/eviction controller downstream of sa_cache. Services one miss at a
// time: optional dirty-victim writeback, one idle gap cycle, line fill, then a
// one-cycle response pulse carrying the fetched line back to the cache.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cache_miss          : miss level from the cache
//   i_miss_addr         : address of the missing access
//   i_evict             : victim is dirty (qualified by cache_miss)
//   i_evict_addr/_data  : victim line address and data
//   o_memory_line       : fill data returned to the cache (held until next fill)
//   o_memory_response   : one-cycle fill-done pulse
//   o_busy              : controller not idle
//   o_err               : sticky timeout flag
//   mem                 : req/ack memory port (sa_cache_mem_ctrl_if.master)
//
// Build option: define SA_CACHE_MEM_CTRL_TIMEOUT_EN to abort memory requests
// left unacknowledged for TIMEOUT_CYCLES cycles. Otherwise the controller waits
// indefinitely and o_err is tied low.
// ----------------------------------------------------------------------------
module sa_cache_mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_LINE       = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cache_miss,
    input  logic [31:0]                i_miss_addr,
    input  logic                       i_evict,
    input  logic [31:0]                i_evict_addr,
    input  logic [31:0]                i_evict_data,
    output logic [31:0]                o_memory_line,
    output logic                       o_memory_response,
    output logic                       o_busy,
    output logic                       o_err,
    sa_cache_mem_ctrl_if.master        mem
);

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StGap,
        StFill,
        StResp
    } state_e;

    localparam logic [31:0] LineMask = 32'hFFFF_FFC0;

    state_e      state_q, state_d;
    logic [31:0] miss_addr_q, miss_addr_d;
    logic [31:0] evict_addr_q, evict_addr_d;
    logic [31:0] evict_data_q, evict_data_d;
    logic [31:0] line_q, line_d;
    logic        timeout;

`ifdef SA_CACHE_MEM_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            waiting;

    assign waiting = ((state_q == StWb) || (state_q == StFill)) && !mem.mem_ack;
    // Fires on the last allowed cycle so mem_req is high for exactly TIMEOUT_CYCLES.
    assign timeout = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Counter falls back to zero whenever not waiting, which clears it on every
    // state entry.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (timeout) begin
            err_d = 1'b1;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    logic unused_timeout;

    assign timeout        = 1'b0;
    assign o_err          = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        evict_addr_d = evict_addr_q;
        evict_data_d = evict_data_q;
        line_d       = line_q;
        unique case (state_q)
            StIdle: begin
                if (cache_miss) begin
                    miss_addr_d = i_miss_addr & LineMask;
                    if (i_evict) begin
                        evict_addr_d = i_evict_addr & LineMask;
                        evict_data_d = i_evict_data;
                        state_d      = StWb;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StWb: begin
                // A timed-out writeback is abandoned; the fill still proceeds.
                if (mem.mem_ack || timeout) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StFill;
            end
            StFill: begin
                if (mem.mem_ack) begin
                    line_d  = mem.mem_rdata;
                    state_d = StResp;
                end else if (timeout) begin
                    line_d  = ERR_LINE;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            miss_addr_q  <= '0;
            evict_addr_q <= '0;
            evict_data_q <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            evict_addr_q <= evict_addr_d;
            evict_data_q <= evict_data_d;
            line_q       <= line_d;
        end
    end

    // Request fields come straight from latched registers, so they cannot move
    // while a request is pending.
    always_comb begin
        mem.mem_req   = (state_q == StWb) || (state_q == StFill);
        mem.mem_we    = (state_q == StWb);
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (state_q == StWb) begin
            mem.mem_addr  = evict_addr_q;
            mem.mem_wdata = evict_data_q;
        end else if (state_q == StFill) begin
            mem.mem_addr = miss_addr_q;
        end
    end

    assign o_memory_line     = line_q;
    assign o_memory_response = (state_q == StResp);
    assign o_busy            = (state_q != StIdle);

endmodule

// File: tb/tb_sa_cache_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sa_cache_mem_ctrl
// Directed bench for sa_cache_mem_ctrl. A small memory responder acks each
// request after mem_delay wait cycles (or never, with mem_never set). Inputs
// are driven and outputs sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_sa_cache_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        cache_miss;
    logic [31:0] i_miss_addr;
    logic        i_evict;
    logic [31:0] i_evict_addr;
    logic [31:0] i_evict_data;
    logic [31:0] o_memory_line;
    logic        o_memory_response;
    logic        o_busy;
    logic        o_err;

    int          checks = 0;
    int          errors = 0;

    int          mem_delay = 0;
    bit          mem_never = 0;
    logic [31:0] fill_data = '0;
    int          wait_cnt  = 0;

    sa_cache_mem_ctrl_if mem_bus ();

    sa_cache_mem_ctrl #(
        .TIMEOUT_CYCLES (8),
        .ERR_LINE       (32'hDEAD_BEEF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cache_miss        (cache_miss),
        .i_miss_addr       (i_miss_addr),
        .i_evict           (i_evict),
        .i_evict_addr      (i_evict_addr),
        .i_evict_data      (i_evict_data),
        .o_memory_line     (o_memory_line),
        .o_memory_response (o_memory_response),
        .o_busy            (o_busy),
        .o_err             (o_err),
        .mem               (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack after mem_delay cycles of a pending request.
    always begin
        @(posedge clk);
        #1;
        if (rst || !mem_bus.mem_req || mem_never) begin
            mem_bus.mem_ack = 1'b0;
            wait_cnt        = 0;
        end else if (wait_cnt == mem_delay) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = fill_data;
            wait_cnt          = 0;
        end else begin
            mem_bus.mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_we, o_memory_response, o_busy, o_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {mem_bus.mem_req, mem_bus.mem_we,
                     o_memory_response, o_busy, o_err});
        end
        checks++;
        if ({mem_bus.mem_addr, mem_bus.mem_wdata, o_memory_line} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0", mem_bus.mem_addr,
                     mem_bus.mem_wdata, o_memory_line);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_clean_miss();
        int cyc;
        int nreq;
        mem_delay   = 0;
        fill_data   = 32'hA5A5_0001;
        cache_miss  = 1'b1;
        i_evict     = 1'b0;
        i_miss_addr = 32'h0001_2345;
        cyc  = 0;
        nreq = 0;
        for (int k = 1; k <= 20 && cyc == 0; k++) begin
            step();
            if (mem_bus.mem_req) begin
                nreq++;
                checks++;
                if (mem_bus.mem_we !== 1'b0 || mem_bus.mem_addr !== 32'h0001_2340) begin
                    errors++;
                    $display("FAIL clean_req: got we=%b addr=%h want we=0 addr=00012340",
                             mem_bus.mem_we, mem_bus.mem_addr);
                end
            end
            if (o_memory_response) cyc = k;
        end
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL clean_latency: got %0d want 2", cyc);
        end
        checks++;
        if (nreq != 1) begin
            errors++;
            $display("FAIL clean_nreq: got %0d want 1", nreq);
        end
        checks++;
        if (o_memory_line !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL clean_line: got %h want a5a50001", o_memory_line);
        end
        step();
        cache_miss = 1'b0;
        checks++;
        if (o_memory_response !== 1'b0 || o_busy !== 1'b0 || o_memory_line !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL clean_after: got resp=%b busy=%b line=%h want 0 0 a5a50001",
                     o_memory_response, o_busy, o_memory_line);
        end
        step();
    endtask

    task automatic test_dirty_miss();
        int wr;
        int rd;
        int gap;
        int nresp;
        int cyc;
        mem_delay    = 3;
        fill_data    = 32'hC0DE_0002;
        cache_miss   = 1'b1;
        i_evict      = 1'b1;
        i_miss_addr  = 32'h0004_5678;
        i_evict_addr = 32'h0000_0F40;
        i_evict_data = 32'h1234_5678;
        wr = 0; rd = 0; gap = 0; nresp = 0; cyc = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 7) begin
                // Inputs changing mid-transaction must not reach the memory port.
                i_miss_addr  = 32'hFFFF_FFFF;
                i_evict      = 1'b0;
                i_evict_addr = 32'h0BAD_0000;
            end
            if (cyc != 0 && k == cyc + 1) cache_miss = 1'b0;
            if (mem_bus.mem_req && mem_bus.mem_we) begin
                wr++;
                checks++;
                if (mem_bus.mem_addr !== 32'h0000_0F40 || mem_bus.mem_wdata !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL dirty_wr: got addr=%h data=%h want 00000f40 12345678",
                             mem_bus.mem_addr, mem_bus.mem_wdata);
                end
            end
            if (mem_bus.mem_req && !mem_bus.mem_we) begin
                rd++;
                checks++;
                if (mem_bus.mem_addr !== 32'h0004_5640 || wr != 4 || gap != 1) begin
                    errors++;
                    $display("FAIL dirty_rd: got addr=%h wr=%0d gap=%0d want 00045640 4 1",
                             mem_bus.mem_addr, wr, gap);
                end
            end
            if (o_busy && !mem_bus.mem_req && !o_memory_response) gap++;
            if (o_memory_response) begin
                nresp++;
                if (cyc == 0) cyc = k;
            end
        end
        checks++;
        if (wr != 4 || rd != 4 || gap != 1) begin
            errors++;
            $display("FAIL dirty_counts: got wr=%0d rd=%0d gap=%0d want 4 4 1", wr, rd, gap);
        end
        checks++;
        if (nresp != 1 || cyc != 10) begin
            errors++;
            $display("FAIL dirty_resp: got pulses=%0d at=%0d want 1 at 10", nresp, cyc);
        end
        checks++;
        if (o_memory_line !== 32'hC0DE_0002 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL dirty_line: got line=%h busy=%b want c0de0002 0", o_memory_line, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        mem_delay   = 0;
        fill_data   = 32'h1111_1111;
        i_evict     = 1'b0;
        cache_miss  = 1'b1;
        i_miss_addr = 32'h0000_1040;
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_1040) begin
            errors++;
            $display("FAIL b2b_req1: got req=%b addr=%h want 1 00001040",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        step();
        checks++;
        if (o_memory_response !== 1'b1 || o_memory_line !== 32'h1111_1111) begin
            errors++;
            $display("FAIL b2b_resp1: got resp=%b line=%h want 1 11111111",
                     o_memory_response, o_memory_line);
        end
        // Cache presents the next miss immediately; RESP must ignore it.
        i_miss_addr = 32'h0000_2080;
        fill_data   = 32'h2222_2222;
        step();
        checks++;
        if (o_busy !== 1'b0 || mem_bus.mem_req !== 1'b0 || o_memory_response !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b req=%b resp=%b want 0 0 0",
                     o_busy, mem_bus.mem_req, o_memory_response);
        end
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0000_2080) begin
            errors++;
            $display("FAIL b2b_req2: got req=%b addr=%h want 1 00002080",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        step();
        cache_miss = 1'b0;
        checks++;
        if (o_memory_response !== 1'b1 || o_memory_line !== 32'h2222_2222) begin
            errors++;
            $display("FAIL b2b_resp2: got resp=%b line=%h want 1 22222222",
                     o_memory_response, o_memory_line);
        end
        step();
        step();
        checks++;
        if (o_busy !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got busy=%b req=%b want 0 0", o_busy, mem_bus.mem_req);
        end
    endtask

    task automatic test_reset_mid_fill();
        mem_never   = 1'b1;
        cache_miss  = 1'b1;
        i_evict     = 1'b0;
        i_miss_addr = 32'h0003_0004;
        step();
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0003_0000) begin
            errors++;
            $display("FAIL midrst_pre: got req=%b addr=%h want 1 00030000",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_bus.mem_req, mem_bus.mem_we, o_memory_response, o_busy, o_err} !== 5'b0 ||
            mem_bus.mem_addr !== 32'h0 || o_memory_line !== 32'h0) begin
            errors++;
            $display("FAIL midrst_out: got ctrl=%b addr=%h line=%h want 0", {mem_bus.mem_req,
                     mem_bus.mem_we, o_memory_response, o_busy, o_err}, mem_bus.mem_addr,
                     o_memory_line);
        end
        cache_miss = 1'b0;
        mem_never  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        fill_data   = 32'h3333_3333;
        cache_miss  = 1'b1;
        i_miss_addr = 32'h0003_0044;
        step();
        checks++;
        if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h0003_0040) begin
            errors++;
            $display("FAIL midrst_req: got req=%b addr=%h want 1 00030040",
                     mem_bus.mem_req, mem_bus.mem_addr);
        end
        step();
        cache_miss = 1'b0;
        checks++;
        if (o_memory_response !== 1'b1 || o_memory_line !== 32'h3333_3333) begin
            errors++;
            $display("FAIL midrst_resp: got resp=%b line=%h want 1 33333333",
                     o_memory_response, o_memory_line);
        end
        step();
    endtask

`ifdef SA_CACHE_MEM_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int reqs;
        int cyc;
        mem_never   = 1'b1;
        cache_miss  = 1'b1;
        i_evict     = 1'b0;
        i_miss_addr = 32'h0005_0010;
        reqs = 0;
        cyc  = 0;
        for (int k = 1; k <= 30 && cyc == 0; k++) begin
            step();
            if (mem_bus.mem_req) reqs++;
            if (o_memory_response) cyc = k;
        end
        checks++;
        if (reqs != 8 || cyc != 9) begin
            errors++;
            $display("FAIL to_cycles: got req=%0d resp_at=%0d want 8 9", reqs, cyc);
        end
        checks++;
        if (o_err !== 1'b1 || o_memory_line !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL to_err: got err=%b line=%h want 1 deadbeef", o_err, o_memory_line);
        end
        cache_miss = 1'b0;
        mem_never  = 1'b0;
        step();
        step();
        fill_data   = 32'h4444_4444;
        cache_miss  = 1'b1;
        i_miss_addr = 32'h0005_0080;
        step();
        step();
        cache_miss = 1'b0;
        checks++;
        if (o_memory_response !== 1'b1 || o_memory_line !== 32'h4444_4444 || o_err !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: got resp=%b line=%h err=%b want 1 44444444 1",
                     o_memory_response, o_memory_line, o_err);
        end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("FAIL to_clear: got err=%b want 0", o_err);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask
`else
    task automatic test_no_timeout();
        int reqs;
        int bad;
        int cyc;
        mem_never   = 1'b1;
        cache_miss  = 1'b1;
        i_evict     = 1'b0;
        i_miss_addr = 32'h0005_0010;
        reqs = 0;
        bad  = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (mem_bus.mem_req) reqs++;
            if (o_err !== 1'b0 || o_memory_response !== 1'b0) bad++;
        end
        checks++;
        if (reqs != 30 || bad != 0 || mem_bus.mem_addr !== 32'h0005_0000) begin
            errors++;
            $display("FAIL nto_wait: got req=%0d bad=%0d addr=%h want 30 0 00050000",
                     reqs, bad, mem_bus.mem_addr);
        end
        fill_data = 32'h4444_4444;
        mem_never = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 6 && cyc == 0; k++) begin
            step();
            if (o_memory_response) cyc = k;
        end
        cache_miss = 1'b0;
        checks++;
        if (cyc == 0 || o_memory_line !== 32'h4444_4444 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL nto_resp: got at=%0d line=%h err=%b want resp 44444444 0",
                     cyc, o_memory_line, o_err);
        end
        step();
    endtask
`endif

    initial begin
        rst          = 1'b1;
        cache_miss   = 1'b0;
        i_miss_addr  = '0;
        i_evict      = 1'b0;
        i_evict_addr = '0;
        i_evict_data = '0;
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_back_to_back();
        test_reset_mid_fill();
`ifdef SA_CACHE_MEM_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1);
    end

endmodule
